// File: rtl/profile_gen_multi.sv
// Multi-channel motion-profile integrator: each channel holds ORDER+1 words
// (position .. top derivative); a step folds every word into the one below it
// with a single shared adder, one update per cycle.
// Latency: busy for CHANNELS*ORDER cycles after acc_step, then a one-cycle done.
// Readback is registered and returns the value held at the preceding edge.
// Backpressure: acc_step while busy is dropped (err[0]); writes while busy are dropped (err[1]).
// Build option: define PROFILE_GEN_SAT_EN to clamp on signed overflow; otherwise sums wrap.
// Ports: clk/rst (async active-low), acc_step, param_addr/param_in/param_write_hi/_lo,
//        rd_addr/rd_data, busy, done, err[1:0], err_clr.
module profile_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int ORDER    = 3,
    parameter int WIDTH    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_step,
    input  logic [7:0]  param_addr,
    input  logic [31:0] param_in,
    input  logic        param_write_hi,
    input  logic        param_write_lo,
    input  logic [7:0]  rd_addr,
    output logic [63:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    input  logic        err_clr
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         ch_q, ch_d;
    logic [3:0]         idx_q, idx_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic [63:0]        rd_q, rd_d;
    logic [WIDTH-1:0]   x_q [CHANNELS][ORDER+1];

    logic               wr_req, wr_ok, wr_rej, upd_en, step_last;
    logic [WIDTH-1:0]   op_a, op_b, sum_raw, sum;
    logic signed [WIDTH-1:0] rd_sel;

    assign wr_req    = param_write_hi | param_write_lo;
    assign wr_ok     = wr_req && (state_q == IDLE);
    assign wr_rej    = wr_req && (state_q == RUN);
    assign step_last = (ch_q == 4'(CHANNELS - 1)) && (idx_q == 4'(ORDER - 1));

    // Sequencer: walks channel-major, index-ascending so every update sees
    // the pre-step value of the next-higher derivative.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        upd_en  = 1'b0;
        err_d   = err_clr ? 2'b00 : err_q;
        case (state_q)
            IDLE: begin
                if (acc_step) begin
                    state_d = RUN;
                    ch_d    = 4'd0;
                    idx_d   = 4'd0;
                end
            end
            RUN: begin
                upd_en = 1'b1;
                if (acc_step) err_d[0] = 1'b1;
                if (step_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (idx_q == 4'(ORDER - 1)) begin
                    idx_d = 4'd0;
                    ch_d  = ch_q + 4'd1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Set beats clear when both happen in the same cycle.
        if (wr_rej) err_d[1] = 1'b1;
    end

    // Shared adder operand select.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i < ORDER; i++) begin
                if (ch_q == 4'(c) && idx_q == 4'(i)) begin
                    op_a = x_q[c][i];
                    op_b = x_q[c][i+1];
                end
            end
        end
    end

    assign sum_raw = op_a + op_b;

`ifdef PROFILE_GEN_SAT_EN
    // Overflow only when both operands share a sign the result lacks.
    always_comb begin
        sum = sum_raw;
        if ((op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_raw[WIDTH-1] != op_a[WIDTH-1])) begin
            sum = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = sum_raw;
`endif

    // Readback select; unmapped addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int i = 0; i <= ORDER; i++) begin
                if (rd_addr[7:4] == 4'(c) && rd_addr[3:0] == 4'(i)) rd_sel = x_q[c][i];
            end
        end
        rd_d = 64'(rd_sel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q    <= 4'd0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
            rd_q    <= 64'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Accumulator storage. Writes are only taken in IDLE and updates only in
    // RUN, so the two paths never target the same word in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i <= ORDER; i++) x_q[c][i] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i <= ORDER; i++) begin
                    if (wr_ok && param_addr[7:4] == 4'(c) && param_addr[3:0] == 4'(i)) begin
                        if (param_write_hi) x_q[c][i][WIDTH-1:32] <= param_in[WIDTH-33:0];
                        if (param_write_lo) x_q[c][i][31:0]       <= param_in;
                    end
                    if (i < ORDER && upd_en && ch_q == 4'(c) && idx_q == 4'(i)) begin
                        x_q[c][i] <= sum;
                    end
                end
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign err     = err_q;
    assign rd_data = rd_q;

endmodule
